// File: rtl/pulse_stretch_universal_pkg.sv
// Shared definitions for the pulse stretcher and related button/LED helpers.
// Holds the channel state encoding and counter sizing functions.
package pulse_stretch_universal_pkg;

    typedef enum logic {
        PS_IDLE   = 1'b0,
        PS_ACTIVE = 1'b1
    } ps_state_e;

    localparam int PS_MAX_HOLD = (1 << 24) - 1;

    // Width of a down-counter able to hold the value 'hold'.
    function automatic int ps_cnt_width(input int hold);
        int w;
        w = $clog2(hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Legal hold range for a stretcher channel.
    function automatic bit ps_hold_legal(input int hold);
        return (hold >= 1) && (hold <= PS_MAX_HOLD);
    endfunction

endpackage

// File: rtl/pulse_stretch_universal_channel.sv
// One stretcher channel: IDLE/ACTIVE FSM with a hold down-counter.
// Outputs come straight from registers; done is a one-cycle pulse.
module pulse_stretch_channel
    import pulse_stretch_universal_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000,
    parameter int RETRIGGER   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic clr,
    output logic stretched,
    output logic done
);

    localparam int CW = ps_cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(1);
    localparam bit RETRIG_EN = (RETRIGGER != 0);

    ps_state_e     r_state;
    ps_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_last;

    // The count equals the remaining high cycles including the current
    // one, so the last active cycle is the one holding 1. Using <= keeps
    // a stray zero from ever wrapping.
    assign w_last = (r_cnt <= TERM);

    // Next-state, counter and done-pulse logic; clr wins over trig.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (clr) begin
            w_state_nxt = PS_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                PS_IDLE: begin
                    if (trig) begin
                        w_state_nxt = PS_ACTIVE;
                        w_cnt_nxt   = LOAD;
                    end
                end
                PS_ACTIVE: begin
                    if (trig && RETRIG_EN) begin
                        w_cnt_nxt = LOAD;
                    end else if (w_last) begin
                        w_state_nxt = PS_IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - TERM;
                    end
                end
            endcase
        end
    end

    // State, counter and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PS_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign stretched = (r_state == PS_ACTIVE);
    assign done      = r_done;

endmodule

// File: rtl/pulse_stretch_universal.sv
// Multi-channel pulse stretcher: WIDTH independent channels.
// The top only replicates channels and forms the busy reduction.
module pulse_stretch_universal
    import pulse_stretch_universal_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int HOLD_CYCLES = 1000,
    parameter int RETRIGGER   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] trig,
    input  logic             clr,
    output logic [WIDTH-1:0] stretched,
    output logic [WIDTH-1:0] done,
    output logic             busy
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            pulse_stretch_channel #(
                .HOLD_CYCLES (HOLD_CYCLES),
                .RETRIGGER   (RETRIGGER)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .trig      (trig[gi]),
                .clr       (clr),
                .stretched (stretched[gi]),
                .done      (done[gi])
            );
        end
    endgenerate

    assign busy = |stretched;

endmodule
